// File: rtl/mem_stream_reader.sv
// Burst reader: walks a combinational-read memory from a base address and
// streams the words out over a valid/ready interface with a last marker.
module mem_stream_reader #(
  parameter int DataWidth = 128,
  parameter int DataDepth = 64,
  parameter int AddrWidth = (DataDepth <= 1) ? 1 : $clog2(DataDepth)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [AddrWidth-1:0]        base_addr_i,
  input  logic [AddrWidth:0]          len_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [AddrWidth-1:0]        mem_addr_o,
  output logic                        mem_we_o,
  output logic signed [DataWidth-1:0] mem_wr_data_o,
  input  logic signed [DataWidth-1:0] mem_rd_data_i,
  output logic signed [DataWidth-1:0] data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        last_o
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(DataDepth - 1);
  localparam logic [AddrWidth:0]   RemOne   = (AddrWidth + 1)'(1);

  state_e                      state_q, state_d;
  logic [AddrWidth-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AddrWidth:0]          remaining_q, remaining_d;
  logic signed [DataWidth-1:0] data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        last_q, last_d;

  // Explicit compare keeps the wrap correct for non-power-of-2 depths.
  function automatic logic [AddrWidth-1:0] wrap_inc(input logic [AddrWidth-1:0] p);
    return (p == LastAddr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d     = STREAM;
            rd_ptr_d    = base_addr_i;
            remaining_d = len_i;
          end else begin
            state_d = DONE;
          end
        end
      end
      STREAM: begin
        // Output register is free to take a new word, or drains the final one.
        if (!valid_q || ready_i) begin
          if (remaining_q != '0) begin
            data_d      = mem_rd_data_i;
            valid_d     = 1'b1;
            last_d      = (remaining_q == RemOne);
            rd_ptr_d    = wrap_inc(rd_ptr_q);
            remaining_d = remaining_q - 1'b1;
          end else if (valid_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign mem_addr_o    = rd_ptr_q;
  assign mem_we_o      = 1'b0;
  assign mem_wr_data_o = '0;
  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign last_o        = last_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: directed scenarios plus randomized bursts,
// each checked against a queue-based model of the expected word stream.
module tb_mem_stream_reader;
  localparam int DW = 128;
  localparam int DD = 64;
  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_i, start_i, ready_i;
  logic [AW-1:0]        base_addr_i;
  logic [AW:0]          len_i;
  logic                 busy_o, done_o, mem_we_o, valid_o, last_o;
  logic [AW-1:0]        mem_addr_o;
  logic signed [DW-1:0] mem_wr_data_o, mem_rd_data_i, data_o;

  logic signed [DW-1:0] mem [DD];
  assign mem_rd_data_i = mem[mem_addr_o];

  mem_stream_reader #(.DataWidth(DW), .DataDepth(DD), .AddrWidth(AW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_wr_data_o(mem_wr_data_o), .mem_rd_data_i(mem_rd_data_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [DW-1:0] obs_data[$];
  bit                   obs_last[$];
  int                   obs_cyc[$];
  int                   obs_addr[$];
  int done_cnt, done_cyc, valid_seen, stab_err, we_err, timed_out;

  task automatic fill_linear();
    for (int i = 0; i < DD; i++) mem[i] = DW'(i + 100);
  endtask

  task automatic start_burst(input int base, input int len);
    @(negedge clk);
    base_addr_i = AW'(base);
    len_i       = (AW + 1)'(len);
    start_i     = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Runs the bus until the burst finishes, recording what the DUT delivers.
  // mode: 0 ready high, 1 ready 1,0,0 repeating, 2 random ready.
  task automatic collect(input int len, input int mode, input bit poke);
    int cyc, loads;
    bit prev_v, prev_r, prev_l;
    logic signed [DW-1:0] prev_d;
    obs_data.delete(); obs_last.delete(); obs_cyc.delete(); obs_addr.delete();
    done_cnt = 0; done_cyc = -1; valid_seen = 0; stab_err = 0; we_err = 0; timed_out = 0;
    loads = 0; prev_v = 0; prev_r = 0; prev_l = 0; prev_d = '0;
    cyc = 0;
    while (1) begin
      if (cyc > 0) @(negedge clk);
      if (cyc > 500) begin timed_out = 1; break; end
      if (done_cnt > 0 && !busy_o) break;
      if (prev_v && !prev_r && (!valid_o || data_o !== prev_d || last_o !== prev_l)) stab_err++;
      if (valid_o) valid_seen++;
      if (mem_we_o !== 1'b0 || mem_wr_data_o !== '0) we_err++;
      if (done_o) begin done_cnt++; done_cyc = cyc; end
      case (mode)
        0:       ready_i = 1'b1;
        1:       ready_i = (cyc % 3 == 0);
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
      if (poke) begin
        start_i     = busy_o;
        base_addr_i = AW'(40);
        len_i       = (AW + 1)'(3);
      end
      if (busy_o && !done_o && (!valid_o || ready_i) && loads < len) begin
        obs_addr.push_back(int'(mem_addr_o));
        loads++;
      end
      if (valid_o && ready_i) begin
        obs_data.push_back(data_o);
        obs_last.push_back(last_o);
        obs_cyc.push_back(cyc);
      end
      prev_v = valid_o; prev_r = ready_i; prev_d = data_o; prev_l = last_o;
      cyc++;
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    n_checks++; if (last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", last_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_o); end
    n_checks++; if (data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", data_o); end
    n_checks++; if (mem_addr_o !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", mem_addr_o); end
    n_checks++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", mem_we_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_basic();
    logic signed [DW-1:0] exp;
    fill_linear();
    start_burst(3, 4);
    collect(4, 0, 0);
    n_checks++; if (timed_out != 0 || obs_data.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d words timeout=%0d expected 4", obs_data.size(), timed_out); end
    for (int k = 0; k < obs_data.size(); k++) begin
      exp = DW'(103 + k);
      n_checks++; if (obs_data[k] !== exp) begin n_fail++; $display("FAIL basic_data[%0d]: got %0d expected %0d", k, obs_data[k], exp); end
      n_checks++; if (obs_cyc[k] != k + 1) begin n_fail++; $display("FAIL basic_cycle[%0d]: got %0d expected %0d", k, obs_cyc[k], k + 1); end
      n_checks++; if (obs_last[k] !== (k == 3)) begin n_fail++; $display("FAIL basic_last[%0d]: got %b expected %b", k, obs_last[k], k == 3); end
    end
    n_checks++; if (done_cnt != 1 || done_cyc != 5) begin n_fail++; $display("FAIL basic_done: got count %0d at cycle %0d expected 1 at 5", done_cnt, done_cyc); end
  endtask

  task automatic test_wrap();
    int exp_a[4] = '{62, 63, 0, 1};
    fill_linear();
    start_burst(62, 4);
    collect(4, 0, 0);
    n_checks++; if (obs_addr.size() != 4 || obs_data.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d addrs %0d words expected 4", obs_addr.size(), obs_data.size()); end
    for (int k = 0; k < obs_addr.size() && k < 4; k++) begin
      n_checks++; if (obs_addr[k] != exp_a[k]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", k, obs_addr[k], exp_a[k]); end
    end
    for (int k = 0; k < obs_data.size() && k < 4; k++) begin
      n_checks++; if (obs_data[k] !== DW'(exp_a[k] + 100)) begin n_fail++; $display("FAIL wrap_data[%0d]: got %0d expected %0d", k, obs_data[k], exp_a[k] + 100); end
    end
  endtask

  task automatic test_stall();
    fill_linear();
    start_burst(5, 5);
    collect(5, 1, 0);
    n_checks++; if (timed_out != 0 || obs_data.size() != 5) begin n_fail++; $display("FAIL stall_count: got %0d words timeout=%0d expected 5", obs_data.size(), timed_out); end
    for (int k = 0; k < obs_data.size(); k++) begin
      n_checks++; if (obs_data[k] !== DW'(105 + k)) begin n_fail++; $display("FAIL stall_data[%0d]: got %0d expected %0d", k, obs_data[k], 105 + k); end
      n_checks++; if (obs_last[k] !== (k == 4)) begin n_fail++; $display("FAIL stall_last[%0d]: got %b expected %b", k, obs_last[k], k == 4); end
    end
    n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", stab_err); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL stall_done: got %0d pulses expected 1", done_cnt); end
  endtask

  task automatic test_zero_len();
    start_burst(7, 0);
    collect(0, 0, 0);
    n_checks++; if (done_cnt != 1 || done_cyc != 0) begin n_fail++; $display("FAIL zero_done: got count %0d at cycle %0d expected 1 at 0", done_cnt, done_cyc); end
    n_checks++; if (valid_seen != 0) begin n_fail++; $display("FAIL zero_valid: got %0d valid cycles expected 0", valid_seen); end
    n_checks++; if (timed_out != 0) begin n_fail++; $display("FAIL zero_timeout: got %0d expected 0", timed_out); end
  endtask

  task automatic test_reset_mid();
    int dn, vl;
    fill_linear();
    start_burst(0, 6);
    ready_i = 1'b1;
    @(negedge clk);
    n_checks++; if (valid_o !== 1'b1 || data_o !== DW'(100)) begin n_fail++; $display("FAIL rstmid_w0: got v=%b d=%0d expected v=1 d=100", valid_o, data_o); end
    @(negedge clk);
    n_checks++; if (valid_o !== 1'b1 || data_o !== DW'(101)) begin n_fail++; $display("FAIL rstmid_w1: got v=%b d=%0d expected v=1 d=101", valid_o, data_o); end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    n_checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_abort: got v=%b busy=%b done=%b expected 0 0 0", valid_o, busy_o, done_o); end
    dn = 0; vl = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_o) dn++;
      if (valid_o) vl++;
    end
    n_checks++; if (dn != 0 || vl != 0) begin n_fail++; $display("FAIL rstmid_quiet: got done %0d valid %0d expected 0 0", dn, vl); end
    start_burst(0, 2);
    collect(2, 0, 0);
    n_checks++; if (obs_data.size() != 2) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 2", obs_data.size()); end
    for (int k = 0; k < obs_data.size(); k++) begin
      n_checks++; if (obs_data[k] !== DW'(100 + k)) begin n_fail++; $display("FAIL rstmid_data[%0d]: got %0d expected %0d", k, obs_data[k], 100 + k); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rstmid_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_start_busy();
    fill_linear();
    start_burst(10, 5);
    collect(5, 2, 1);
    n_checks++; if (timed_out != 0 || obs_data.size() != 5) begin n_fail++; $display("FAIL busy_count: got %0d words timeout=%0d expected 5", obs_data.size(), timed_out); end
    for (int k = 0; k < obs_data.size(); k++) begin
      n_checks++; if (obs_data[k] !== DW'(110 + k)) begin n_fail++; $display("FAIL busy_data[%0d]: got %0d expected %0d", k, obs_data[k], 110 + k); end
    end
    n_checks++; if (we_err != 0) begin n_fail++; $display("FAIL busy_we: got %0d write cycles expected 0", we_err); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_done: got %0d expected 1", done_cnt); end
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL busy_requeue: got busy %b expected 0", busy_o); end
  endtask

  task automatic test_random();
    int base, len, errs;
    logic signed [DW-1:0] exp;
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < DD; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
      base = $urandom_range(0, DD - 1);
      len  = (it == 0) ? DD : $urandom_range(0, DD);
      start_burst(base, len);
      collect(len, 2, 0);
      n_checks++; if (timed_out != 0 || obs_data.size() != len) begin n_fail++; $display("FAIL rand%0d_count: got %0d words timeout=%0d expected %0d", it, obs_data.size(), timed_out, len); end
      errs = 0;
      for (int k = 0; k < obs_data.size() && k < len; k++) begin
        exp = mem[(base + k) % DD];
        if (obs_data[k] !== exp || obs_last[k] !== (k == len - 1) || obs_addr[k] != (base + k) % DD) errs++;
      end
      n_checks++; if (errs != 0) begin n_fail++; $display("FAIL rand%0d_stream: got %0d bad words expected 0 (base %0d len %0d)", it, errs, base, len); end
      n_checks++; if (done_cnt != 1 || stab_err != 0) begin n_fail++; $display("FAIL rand%0d_ctrl: got done %0d unstable %0d expected 1 0", it, done_cnt, stab_err); end
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; ready_i = 1'b0;
    base_addr_i = '0; len_i = '0;
    fill_linear();
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_len();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
